mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares one single-port memory bus between two requesters: the cpu instruction-fetch path (port i) and the load/store path (port d).
- Serialises the two requesters through a small FSM. Each access is held on the memory side until the memory acknowledges it.
- Returns the read data and a one-cycle ack pulse to the requester that owns the access.
- Sits between the cpu core and the shared rom/ram, so rom-based fetch can coexist with data loads and stores.

Parameters:
- AW, 32, address width in bits.
- DW, 32, data width in bits. Byte-enable width is DW/8.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- i_req  in  1  fetch request; held high with i_addr stable until i_ack.
- i_addr  in  AW  fetch byte address.
- i_rdata  out  DW  fetched word; valid while i_ack=1.
- i_ack  out  1  one-cycle completion pulse for fetch.
- d_req  in  1  load/store request; held high with d_* inputs stable until d_ack.
- d_we  in  1  1=store, 0=load.
- d_be  in  DW/8  store byte enables.
- d_addr  in  AW  data byte address.
- d_wdata  in  DW  store data.
- d_rdata  out  DW  load data; valid while d_ack=1.
- d_ack  out  1  one-cycle completion pulse for data.
- m_req  out  1  memory request; held until m_ack.
- m_we  out  1  memory write enable.
- m_be  out  DW/8  memory byte enables.
- m_addr  out  AW  memory byte address.
- m_wdata  out  DW  memory write data.
- m_rdata  in  DW  memory read data; sampled when m_ack=1.
- m_ack  in  1  memory completion; may be asserted in the first cycle m_req is high.

Behaviour:
- Reset: state=IDLE. All outputs are 0 (m_req, m_we, m_be, m_addr, m_wdata, i_ack, d_ack, i_rdata, d_rdata). The last-grant flag is set to "fetch".
- FSM states: IDLE, BUSY_I, BUSY_D, DONE.
- IDLE:
  - If d_req=1, go to BUSY_D and register d_we, d_be, d_addr, d_wdata into m_*.
  - Else if i_req=1, go to BUSY_I with m_we=0, m_be=all-ones, m_addr=i_addr, m_wdata=0.
  - Set m_req<=1 on the same edge as the BUSY transition.
- BUSY_x: m_* are held constant.
  - On m_ack=1: m_req<=0, the owner's rdata<=m_rdata, the owner's ack<=1, go to DONE.
- DONE: the ack is high for exactly this cycle; clear it and return to IDLE.
- Requester obligation: drop req on the edge ending the ack cycle. The arbiter samples req again only in IDLE.
- Minimum latency: request seen at cycle 0 → m_req at 1 → m_ack at 1 → ack at 2 → IDLE at 3. Throughput is at most one access per 3 cycles.
- Stores: d_rdata still captures m_rdata. The cpu ignores it for stores.
- m_ack outside BUSY_x is ignored and has no effect.
- Simultaneous i_req and d_req in IDLE: data wins (fixed priority) unless MEM_ARB_RR_EN is defined.
- Reset mid-access: m_req drops after the reset edge and no ack is ever issued for the abandoned access. The memory must tolerate the abort.
- Address alignment is not checked; m_addr is passed through unchanged.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Defined: round-robin arbitration. The last-grant flag updates on every grant. When both requests are pending in IDLE, grant goes to the port not granted last. A single pending request is always granted.
- Undefined: the flag logic is absent and data always has priority. A back-to-back data stream may starve fetch.

Decomposition:
- Shared header mem_arb.vh holds:
  - state encodings ST_IDLE=0, ST_BUSY_I=1, ST_BUSY_D=2, ST_DONE=3;
  - grant encodings GNT_I=0, GNT_D=1.
- One sub-module, arb_pick: combinational priority/round-robin selector taking i_req, d_req and last_gnt, producing gnt_valid and gnt_id.
- The FSM and registers stay in mem_arbiter.

Test Plan:
- Single fetch, i_addr=0x10, memory acks next cycle with 0xDEADBEEF → m_addr=0x10, m_we=0, m_be=0xF; i_ack pulses 1 cycle with i_rdata=0xDEADBEEF; d_ack stays 0.
- Store d_addr=0x20, be=0x3, wdata=0x1234, memory ack delayed 4 cycles → m_* held stable for all 4 cycles; d_ack is a single pulse; returns to IDLE.
- i_req and d_req raised in the same cycle, without RR_EN → data served first, then fetch; acks separated by ≥3 cycles.
- With MEM_ARB_RR_EN, both requesters continuously pending for 6 accesses → grant order alternates D,I,D,I,D,I (flag reset to fetch, so D goes first).
- rst asserted while in BUSY_D → next cycle m_req=0, no d_ack ever; after rst release, a fresh i_req completes normally.
- Spurious m_ack pulse in IDLE with no requests → no ack on either port, state stays IDLE.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the two-port memory arbiter: FSM states and grant identifiers.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY_I = 2'd1,
        ST_BUSY_D = 2'd2,
        ST_DONE   = 2'd3
    } arb_state_e;

    localparam logic GNT_I = 1'b0;
    localparam logic GNT_D = 1'b1;

    function automatic arb_state_e busy_state(input logic gnt_id);
        return (gnt_id == GNT_D) ? ST_BUSY_D : ST_BUSY_I;
    endfunction

endpackage

// File: rtl/mem_arbiter_arb_pick.sv
// Combinational selector: a lone request always wins; on a tie the port not granted last wins.
module arb_pick
    import mem_arbiter_pkg::*;
(
    input  logic i_req,
    input  logic d_req,
    input  logic last_gnt,
    output logic gnt_valid,
    output logic gnt_id
);

    always_comb begin
        gnt_valid = i_req | d_req;
        gnt_id    = GNT_I;
        if (i_req && d_req) begin
            gnt_id = (last_gnt == GNT_I) ? GNT_D : GNT_I;
        end else if (d_req) begin
            gnt_id = GNT_D;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises fetch (port i) and load/store (port d) onto one single-port memory bus.
// Define MEM_ARB_RR_EN for round-robin on ties; otherwise data has fixed priority.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_req,
    input  logic [AW-1:0]   i_addr,
    output logic [DW-1:0]   i_rdata,
    output logic            i_ack,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [DW/8-1:0] d_be,
    input  logic [AW-1:0]   d_addr,
    input  logic [DW-1:0]   d_wdata,
    output logic [DW-1:0]   d_rdata,
    output logic            d_ack,
    output logic            m_req,
    output logic            m_we,
    output logic [DW/8-1:0] m_be,
    output logic [AW-1:0]   m_addr,
    output logic [DW-1:0]   m_wdata,
    input  logic [DW-1:0]   m_rdata,
    input  logic            m_ack
);

    localparam int BW = DW / 8;

    arb_state_e      state_q,   state_d;
    logic            m_req_q,   m_req_d;
    logic            m_we_q,    m_we_d;
    logic [BW-1:0]   m_be_q,    m_be_d;
    logic [AW-1:0]   m_addr_q,  m_addr_d;
    logic [DW-1:0]   m_wdata_q, m_wdata_d;
    logic [DW-1:0]   i_rdata_q, i_rdata_d;
    logic [DW-1:0]   d_rdata_q, d_rdata_d;
    logic            i_ack_q,   i_ack_d;
    logic            d_ack_q,   d_ack_d;
    logic            last_gnt;
    logic            gnt_valid;
    logic            gnt_id;

`ifdef MEM_ARB_RR_EN
    logic last_gnt_q, last_gnt_d;

    always_comb begin
        last_gnt_d = last_gnt_q;
        if (state_q == ST_IDLE && gnt_valid) begin
            last_gnt_d = gnt_id;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_gnt_q <= GNT_I;
        end else begin
            last_gnt_q <= last_gnt_d;
        end
    end

    assign last_gnt = last_gnt_q;
`else
    // Pinning the last grant to fetch makes every tie resolve to data.
    assign last_gnt = GNT_I;
`endif

    arb_pick u_pick (
        .i_req     (i_req),
        .d_req     (d_req),
        .last_gnt  (last_gnt),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id)
    );

    always_comb begin
        state_d   = state_q;
        m_req_d   = m_req_q;
        m_we_d    = m_we_q;
        m_be_d    = m_be_q;
        m_addr_d  = m_addr_q;
        m_wdata_d = m_wdata_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        i_ack_d   = 1'b0;
        d_ack_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (gnt_valid) begin
                    state_d = busy_state(gnt_id);
                    m_req_d = 1'b1;
                    if (gnt_id == GNT_D) begin
                        m_we_d    = d_we;
                        m_be_d    = d_be;
                        m_addr_d  = d_addr;
                        m_wdata_d = d_wdata;
                    end else begin
                        m_we_d    = 1'b0;
                        m_be_d    = '1;
                        m_addr_d  = i_addr;
                        m_wdata_d = '0;
                    end
                end
            end
            ST_BUSY_I: begin
                if (m_ack) begin
                    m_req_d   = 1'b0;
                    i_rdata_d = m_rdata;
                    i_ack_d   = 1'b1;
                    state_d   = ST_DONE;
                end
            end
            ST_BUSY_D: begin
                if (m_ack) begin
                    m_req_d   = 1'b0;
                    d_rdata_d = m_rdata;
                    d_ack_d   = 1'b1;
                    state_d   = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            m_req_q   <= 1'b0;
            m_we_q    <= 1'b0;
            m_be_q    <= '0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
            i_ack_q   <= 1'b0;
            d_ack_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            m_req_q   <= m_req_d;
            m_we_q    <= m_we_d;
            m_be_q    <= m_be_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
            i_ack_q   <= i_ack_d;
            d_ack_q   <= d_ack_d;
        end
    end

    assign m_req   = m_req_q;
    assign m_we    = m_we_q;
    assign m_be    = m_be_q;
    assign m_addr  = m_addr_q;
    assign m_wdata = m_wdata_q;
    assign i_rdata = i_rdata_q;
    assign d_rdata = d_rdata_q;
    assign i_ack   = i_ack_q;
    assign d_ack   = d_ack_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter; the bench itself plays cpu and memory cycle by cycle.
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic [DW-1:0] i_rdata;
    logic          i_ack;
    logic          d_req;
    logic          d_we;
    logic [3:0]    d_be;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [DW-1:0] d_rdata;
    logic          d_ack;
    logic          m_req;
    logic          m_we;
    logic [3:0]    m_be;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_rdata;
    logic          m_ack;

    int vectors    = 0;
    int miscompares = 0;
    int cyc        = 0;
    int d_ack_cyc;
    int i_ack_cyc;

    mem_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk     (clk),
        .rst     (rst),
        .i_req   (i_req),
        .i_addr  (i_addr),
        .i_rdata (i_rdata),
        .i_ack   (i_ack),
        .d_req   (d_req),
        .d_we    (d_we),
        .d_be    (d_be),
        .d_addr  (d_addr),
        .d_wdata (d_wdata),
        .d_rdata (d_rdata),
        .d_ack   (d_ack),
        .m_req   (m_req),
        .m_we    (m_we),
        .m_be    (m_be),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_rdata (m_rdata),
        .m_ack   (m_ack)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_mem(input string tag, input logic req, input logic we,
                             input logic [3:0] be, input logic [31:0] addr,
                             input logic [31:0] wdata);
        check({tag, ".m_req"},   64'(m_req),   64'(req));
        check({tag, ".m_we"},    64'(m_we),    64'(we));
        check({tag, ".m_be"},    64'(m_be),    64'(be));
        check({tag, ".m_addr"},  64'(m_addr),  64'(addr));
        check({tag, ".m_wdata"}, 64'(m_wdata), 64'(wdata));
    endtask

    initial begin
        rst = 1'b1; i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_be = 0;
        d_addr = 0; d_wdata = 0; m_rdata = 0; m_ack = 0;
        tick(); tick();
        check_mem("reset", 0, 0, 4'h0, 0, 0);
        check("reset.i_ack", 64'(i_ack), 0);
        check("reset.d_ack", 64'(d_ack), 0);
        check("reset.i_rdata", 64'(i_rdata), 0);
        check("reset.d_rdata", 64'(d_rdata), 0);
        rst = 1'b0;
        tick();

        // single fetch, memory acks in the cycle after m_req rises
        i_req = 1; i_addr = 32'h10;
        tick();
        check_mem("fetch.req", 1, 0, 4'hF, 32'h10, 0);
        m_ack = 1; m_rdata = 32'hDEADBEEF;
        tick();
        check("fetch.i_ack", 64'(i_ack), 1);
        check("fetch.i_rdata", 64'(i_rdata), 64'hDEADBEEF);
        check("fetch.d_ack", 64'(d_ack), 0);
        check("fetch.m_req_drop", 64'(m_req), 0);
        m_ack = 0; i_req = 0;
        tick();
        check("fetch.i_ack_end", 64'(i_ack), 0);
        check("fetch.d_ack_end", 64'(d_ack), 0);

        // store with memory ack after four held cycles
        d_req = 1; d_we = 1; d_be = 4'h3; d_addr = 32'h20; d_wdata = 32'h1234;
        for (int k = 0; k < 4; k++) begin
            tick();
            check_mem("store.hold", 1, 1, 4'h3, 32'h20, 32'h1234);
            check("store.no_ack", 64'(d_ack), 0);
        end
        m_ack = 1; m_rdata = 32'h0000CAFE;
        tick();
        check("store.d_ack", 64'(d_ack), 1);
        check("store.d_rdata", 64'(d_rdata), 64'hCAFE);
        check("store.i_ack", 64'(i_ack), 0);
        m_ack = 0; d_req = 0; d_we = 0;
        tick();
        check("store.d_ack_end", 64'(d_ack), 0);
        check("store.m_req", 64'(m_req), 0);
        tick();
        check("store.idle_m_req", 64'(m_req), 0);

        // reset in the middle of a load; the access is abandoned silently
        d_req = 1; d_be = 4'hF; d_addr = 32'h30;
        tick();
        check("rstmid.m_req", 64'(m_req), 1);
        rst = 1;
        tick();
        check("rstmid.m_req_drop", 64'(m_req), 0);
        check("rstmid.d_ack", 64'(d_ack), 0);
        check("rstmid.m_addr", 64'(m_addr), 0);
        rst = 0; d_req = 0; m_ack = 1; m_rdata = 32'h77;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("rstmid.no_d_ack", 64'(d_ack), 0);
            check("rstmid.no_i_ack", 64'(i_ack), 0);
            check("rstmid.idle", 64'(m_req), 0);
        end
        m_ack = 0;
        i_req = 1; i_addr = 32'h50;
        tick();
        check_mem("rstmid.fetch", 1, 0, 4'hF, 32'h50, 0);
        m_ack = 1; m_rdata = 32'h55;
        tick();
        check("rstmid.i_ack", 64'(i_ack), 1);
        check("rstmid.i_rdata", 64'(i_rdata), 64'h55);
        check("rstmid.d_ack2", 64'(d_ack), 0);
        m_ack = 0; i_req = 0;
        tick();

        // simultaneous requests: data first, then fetch
        i_req = 1; i_addr = 32'h40;
        d_req = 1; d_we = 0; d_be = 4'hF; d_addr = 32'h80; d_wdata = 0;
        tick();
        check_mem("both.first", 1, 0, 4'hF, 32'h80, 0);
        m_ack = 1; m_rdata = 32'hA1;
        tick();
        check("both.d_ack", 64'(d_ack), 1);
        check("both.d_rdata", 64'(d_rdata), 64'hA1);
        check("both.i_ack0", 64'(i_ack), 0);
        d_ack_cyc = cyc;
        m_ack = 0; d_req = 0;
        tick();
        check("both.done", 64'(m_req), 0);
        tick();
        check_mem("both.second", 1, 0, 4'hF, 32'h40, 0);
        m_ack = 1; m_rdata = 32'hB2;
        tick();
        check("both.i_ack", 64'(i_ack), 1);
        check("both.i_rdata", 64'(i_rdata), 64'hB2);
        check("both.d_ack_off", 64'(d_ack), 0);
        i_ack_cyc = cyc;
        check("both.gap", 64'(i_ack_cyc - d_ack_cyc), 64'd3);
        m_ack = 0; i_req = 0;
        tick();

        // spurious m_ack in IDLE with no requests
        m_ack = 1; m_rdata = 32'hFFFF;
        for (int k = 0; k < 2; k++) begin
            tick();
            check("spur.i_ack", 64'(i_ack), 0);
            check("spur.d_ack", 64'(d_ack), 0);
            check("spur.m_req", 64'(m_req), 0);
        end
        m_ack = 0;
        i_req = 1; i_addr = 32'h60;
        tick();
        check_mem("spur.after", 1, 0, 4'hF, 32'h60, 0);
        m_ack = 1; m_rdata = 32'h66;
        tick();
        check("spur.after_ack", 64'(i_ack), 1);
        m_ack = 0; i_req = 0;
        tick();

`ifdef MEM_ARB_RR_EN
        // both ports pending continuously; flag restarts at fetch so data goes first
        rst = 1;
        tick();
        rst = 0;
        i_req = 1; i_addr = 32'h100;
        d_req = 1; d_we = 0; d_be = 4'hF; d_addr = 32'h200;
        for (int k = 0; k < 6; k++) begin
            tick();
            check("rr.order", 64'(m_addr), (k % 2 == 0) ? 64'h200 : 64'h100);
            m_ack = 1; m_rdata = 32'(k);
            tick();
            check("rr.ack_owner", 64'({i_ack, d_ack}), (k % 2 == 0) ? 64'b01 : 64'b10);
            m_ack = 0;
            tick();
        end
        i_req = 0; d_req = 0;
        tick();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
